// File: rtl/picoview_regbank.sv
// picoview_regbank: SPI-facing register bank between simple_spi and a sampling core.
//
// Address map
//   0            CONTROL/STATUS  read {ovf, done, core_running, 0}; write bit0 run,
//                                bit1 abort, bit2 W1C done, bit3 W1C ovf
//   1            RESULT          read-only capture of result_in
//   2..NUM_REGS-1                plain R/W configuration, exported on cfg_flat
//   >= NUM_REGS                  read 0, writes ignored
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   cmd_valid, cmd               command strobe; cmd = {write, auto_inc, addr}
//   word_valid, wdata            data word strobe and received word
//   rdata                        word to shift out on the next transfer
//   run_pulse, abort_pulse       one-cycle requests to the core
//   core_running                 core busy level
//   result_valid, result_in      result capture strobe and data
//   cfg_flat                     general registers, reg k at [(k-2)*DATA_WIDTH +: DATA_WIDTH]
module picoview_regbank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    input  logic [ADDR_WIDTH+1:0]            cmd,
    input  logic                             word_valid,
    input  logic [DATA_WIDTH-1:0]            wdata,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             run_pulse,
    output logic                             abort_pulse,
    input  logic                             core_running,
    input  logic                             result_valid,
    input  logic [DATA_WIDTH-1:0]            result_in,
    output logic [(NUM_REGS-2)*DATA_WIDTH-1:0] cfg_flat
);

    localparam int unsigned NCFG = NUM_REGS - 2;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  wr_flag;
    logic                  ai_flag;
    logic [DATA_WIDTH-1:0] result_reg;
    logic                  done;
    logic                  ovf;
    logic [DATA_WIDTH-1:0] cfg     [NCFG];
    logic [DATA_WIDTH-1:0] cfg_nxt [NCFG];

    logic                  cmd_wr;
    logic                  cmd_ai;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  word_en;
    logic                  wr_en;
    logic                  ctrl_wr;
    logic                  run_req;
    logic                  abort_req;
    logic                  clr_done;
    logic                  clr_ovf;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [DATA_WIDTH-1:0] status_word;
    logic [DATA_WIDTH-1:0] cmd_rd;
    logic [DATA_WIDTH-1:0] rl_rd;

    assign cmd_wr   = cmd[ADDR_WIDTH+1];
    assign cmd_ai   = cmd[ADDR_WIDTH];
    assign cmd_addr = cmd[ADDR_WIDTH-1:0];

    // A command in the same cycle as a word takes priority; the word is lost.
    assign word_en   = word_valid & ~cmd_valid;
    assign wr_en     = word_en & wr_flag;
    assign ctrl_wr   = wr_en & (cur_addr == '0);
    // Abort written together with run suppresses the run.
    assign run_req   = ctrl_wr & wdata[0] & ~wdata[1] & ~core_running;
    assign abort_req = ctrl_wr & wdata[1];
    assign clr_done  = (ctrl_wr & wdata[2]) | run_req;
    assign clr_ovf   = (ctrl_wr & wdata[3]) | run_req;
    assign next_addr = ai_flag ? cur_addr + ADDR_WIDTH'(1) : cur_addr;

    always_comb begin
        status_word      = '0;
        status_word[3:0] = {ovf, done, core_running, 1'b0};
    end

    always_comb begin
        cfg_nxt = cfg;
        for (int unsigned j = 0; j < NCFG; j++) begin
            if (wr_en && cur_addr == ADDR_WIDTH'(j + 2)) begin
                cfg_nxt[j] = wdata;
            end
        end
    end

    // Command reads see current state; the post-word reload reads the config
    // registers through cfg_nxt so a same-cycle write is returned.
    always_comb begin
        cmd_rd = '0;
        rl_rd  = '0;
        if (cmd_addr == '0) begin
            cmd_rd = status_word;
        end else if (cmd_addr == ADDR_WIDTH'(1)) begin
            cmd_rd = result_reg;
        end
        if (next_addr == '0) begin
            rl_rd = status_word;
        end else if (next_addr == ADDR_WIDTH'(1)) begin
            rl_rd = result_reg;
        end
        for (int unsigned j = 0; j < NCFG; j++) begin
            if (cmd_addr == ADDR_WIDTH'(j + 2)) begin
                cmd_rd = cfg[j];
            end
            if (next_addr == ADDR_WIDTH'(j + 2)) begin
                rl_rd = cfg_nxt[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr    <= '0;
            wr_flag     <= 1'b0;
            ai_flag     <= 1'b0;
            rdata       <= '0;
            run_pulse   <= 1'b0;
            abort_pulse <= 1'b0;
            result_reg  <= '0;
            done        <= 1'b0;
            ovf         <= 1'b0;
            for (int unsigned j = 0; j < NCFG; j++) begin
                cfg[j] <= '0;
            end
        end else begin
            if (cmd_valid) begin
                cur_addr <= cmd_addr;
                wr_flag  <= cmd_wr;
                ai_flag  <= cmd_ai;
                rdata    <= cmd_rd;
            end else if (word_en) begin
                cur_addr <= next_addr;
                rdata    <= rl_rd;
            end
            cfg         <= cfg_nxt;
            run_pulse   <= run_req;
            abort_pulse <= abort_req;
            if (result_valid) begin
                result_reg <= result_in;
            end
            // A new result outranks a same-cycle clear.
            if (result_valid) begin
                done <= 1'b1;
            end else if (clr_done) begin
                done <= 1'b0;
            end
            if (result_valid && done) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NCFG; g++) begin : g_flat
        assign cfg_flat[g*DATA_WIDTH +: DATA_WIDTH] = cfg[g];
    end

endmodule
